// File: rtl/stream_mac_pkg.sv
// Shared types, default parameters and sizing helpers for the streaming
// dot-product MAC that drains the two operand FIFOs.
package stream_mac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ACC_WIDTH  = 24;
    localparam int unsigned DEF_COUNT      = 8;

    // Bits needed for a counter that must reach the value count itself.
    function automatic int unsigned cnt_width(input int unsigned count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/stream_mac_pipe.sv
// Datapath for stream_mac: pop-delay valid, registered product, and the
// wrapping accumulator with a sticky carry-out flag.
module mac_pipe
    import stream_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  ovf,
    output logic                  out_valid
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic                  pop_q;
    logic [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]    sum;

    // One extra bit captures the carry-out of the accumulate.
    assign sum = {1'b0, acc} + (ACC_WIDTH + 1)'(prod);

    // out_valid marks a product register that is added on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_q     <= 1'b0;
            out_valid <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            pop_q     <= in_valid;
            out_valid <= pop_q;
            prod      <= PROD_WIDTH'(a) * PROD_WIDTH'(b);
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (out_valid) begin
                acc <= sum[ACC_WIDTH-1:0];
                ovf <= ovf | sum[ACC_WIDTH];
            end
        end
    end

endmodule

// File: rtl/stream_mac.sv
// Pops matched operand pairs from FIFOs A and B, accumulates COUNT products
// per start pulse and holds the dot product with result_valid until restarted.
module stream_mac
    import stream_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned COUNT      = DEF_COUNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_rden,
    output logic                  b_rden,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  ovf
);

    localparam int unsigned   CW    = cnt_width(COUNT);
    localparam logic [CW-1:0] LAST  = CW'(COUNT - 1);
    localparam logic [CW-1:0] TOTAL = CW'(COUNT);

    mac_state_t    state, state_next;
    logic [CW-1:0] issued, issued_next;
    logic [CW-1:0] retired, retired_next;
    logic          busy_next, result_valid_next;
    logic          pop, clr, acc_en;

    // Both FIFOs always pop together; reset suppresses popping immediately.
    assign pop    = rst_n && (state == RUN) && !a_empty && !b_empty && (issued < TOTAL);
    assign a_rden = pop;
    assign b_rden = pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            issued       <= '0;
            retired      <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            issued       <= issued_next;
            retired      <= retired_next;
            busy         <= busy_next;
            result_valid <= result_valid_next;
        end
    end

    always_comb begin
        state_next   = state;
        issued_next  = issued;
        retired_next = retired;
        clr          = 1'b0;

        if (pop)    issued_next  = issued + CW'(1);
        if (acc_en) retired_next = retired + CW'(1);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = RUN;
                    clr          = 1'b1;
                    issued_next  = '0;
                    retired_next = '0;
                end
            end
            RUN:     if (pop && issued == LAST) state_next = DRAIN;
            DRAIN:   if (acc_en && retired == LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase

        busy_next         = (state_next == RUN) || (state_next == DRAIN);
        result_valid_next = (state_next == DONE);
    end

    mac_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (pop),
        .a        (a_data),
        .b        (b_data),
        .acc      (result),
        .ovf      (ovf),
        .out_valid(acc_en)
    );

endmodule

// File: tb/tb_stream_mac.sv
// Directed bench for stream_mac: FIFO models feed the DUT, expected dot
// products are queued at each start and compared when result_valid rises.
`timescale 1ns/1ps
module tb_stream_mac;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 16;
    localparam int unsigned CNT = 8;

    typedef struct {
        logic [AW-1:0] res;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          a_empty, b_empty;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          a_rden, b_rden;
    logic [AW-1:0] result;
    logic          result_valid, busy, ovf;

    logic [DW-1:0] a_mem [0:255];
    logic [DW-1:0] b_mem [0:255];
    int            a_wr = 0, b_wr = 0, a_rd = 0, b_rd = 0;
    logic          flush = 1'b0, stall_en = 1'b0, a_hold = 1'b0, a_force = 1'b0;
    int            pops = 0, viol = 0;
    int            tests = 0, fails = 0;
    exp_t          sb[$];

    always #10 clk = ~clk;

    stream_mac #(
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW),
        .COUNT     (CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a_empty     (a_empty),
        .b_empty     (b_empty),
        .a_data      (a_data),
        .b_data      (b_data),
        .a_rden      (a_rden),
        .b_rden      (b_rden),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .ovf         (ovf)
    );

    // FIFO models: read data appears the cycle after the pop.
    assign a_empty = (a_rd == a_wr) || a_hold || a_force;
    assign b_empty = (b_rd == b_wr);

    always @(posedge clk) begin
        if (flush) begin
            a_rd <= a_wr;
            b_rd <= b_wr;
        end else begin
            if (a_rden) begin
                a_data <= a_mem[a_rd];
                a_rd   <= a_rd + 1;
            end
            if (b_rden) begin
                b_data <= b_mem[b_rd];
                b_rd   <= b_rd + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (stall_en) a_hold <= ~a_hold;
        else          a_hold <= 1'b0;
    end

    // Mid-cycle pop monitor: counts pops and illegal pop conditions.
    always @(negedge clk) begin
        if (a_rden) pops++;
        if (a_rden && (a_empty || b_empty)) viol++;
        if (a_rden !== b_rden) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        a_mem[a_wr] = av;
        b_mem[b_wr] = bv;
        a_wr++;
        b_wr++;
    endtask

    task automatic pulse_start(input logic [AW-1:0] er, input logic eo);
        exp_t e;
        e.res = er;
        e.ovf = eo;
        sb.push_back(e);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Waits for result_valid, then checks latency (if exp_cyc >= 0) and scoreboard head.
    task automatic wait_result(input string tag, input int n0, input int exp_cyc);
        int   n;
        exp_t e;
        n = n0;
        while (!result_valid && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(result_valid), 32'd1);
        if (exp_cyc >= 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, 32'(result), 32'(e.res));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        end
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        start = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_rden", 32'(a_rden), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic run: 1..8 squared sums to 204, valid 11 cycles after start
        for (int i = 1; i <= 8; i++) load(DW'(i), DW'(i));
        p0 = pops;
        pulse_start(16'd204, 1'b0);
        chk("basic_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("basic_rden_burst", 32'(a_rden), 32'd1);
            step();
        end
        chk("basic_rden_after", 32'(a_rden), 32'd0);
        wait_result("basic", 9, 11);
        chk("basic_pops", 32'(pops - p0), 32'd8);
        step();
        chk("basic_hold_valid", 32'(result_valid), 32'd1);

        // Restart from DONE, with a start re-pulse mid-run that must be ignored
        for (int i = 1; i <= 8; i++) load(DW'(i), DW'(i));
        p0 = pops;
        pulse_start(16'd204, 1'b0);
        chk("restart_valid_drop", 32'(result_valid), 32'd0);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_busy", 32'(busy), 32'd1);
        wait_result("busy_start", 0, -1);
        chk("busy_start_pops", 32'(pops - p0), 32'd8);

        // Stall: A empty every other cycle, 2*3*8 = 48
        for (int i = 0; i < 8; i++) load(8'd2, 8'd3);
        p0 = pops;
        viol = 0;
        stall_en = 1'b1;
        pulse_start(16'd48, 1'b0);
        wait_result("stall", 1, -1);
        stall_en = 1'b0;
        chk("stall_pops", 32'(pops - p0), 32'd8);
        chk("stall_violations", 32'(viol), 32'd0);

        // Overflow: 8*255*255 = 520200 mod 65536 = 61448, carry seen
        for (int i = 0; i < 8; i++) load(8'd255, 8'd255);
        pulse_start(16'd61448, 1'b1);
        wait_result("overflow", 1, 11);
        for (int i = 0; i < 8; i++) load(8'd0, 8'd0);
        pulse_start(16'd0, 1'b0);
        chk("ovf_clear_on_start", 32'(ovf), 32'd0);
        wait_result("zeros", 1, 11);

        // Reset after four pops
        for (int i = 1; i <= 8; i++) load(DW'(i), DW'(i));
        p0 = pops;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("mid_partial_result", 32'(result), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rden_in_reset", 32'(a_rden), 32'd0);
        step();
        rst_n = 1'b1;
        chk("mid_result", 32'(result), 32'd0);
        chk("mid_valid", 32'(result_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ovf", 32'(ovf), 32'd0);
        chk("mid_rden", 32'(a_rden), 32'd0);
        chk("mid_pops", 32'(pops - p0), 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 1; i <= 8; i++) load(DW'(i), DW'(i));
        pulse_start(16'd204, 1'b0);
        wait_result("after_reset", 1, 11);

        // A never becomes non-empty: stuck in RUN with no pops
        for (int i = 1; i <= 8; i++) load(DW'(i), DW'(i));
        a_force = 1'b1;
        p0 = pops;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        chk("empty_busy", 32'(busy), 32'd1);
        chk("empty_valid", 32'(result_valid), 32'd0);
        chk("empty_pops", 32'(pops - p0), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_force = 1'b0;
        step();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
